v810_prefetch: RTL and testbench

- Instruction prefetch queue directly upstream of the v810_exec fetch port.
- Issues 32-bit word reads to instruction memory and buffers the returned halfwords.
- Presents each instruction in turn, 16- or 32-bit and halfword-aligned, with its PC.
- Redirects on branch/jump flush from the execute stage.

---
 rtl/v810_pkg.sv | 18 +
 rtl/v810_hwq.sv | 63 ++++++
 rtl/v810_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_v810_prefetch.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v810_pkg.sv
// Shared types and helpers for the V810 instruction prefetch queue.
package v810_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_WAIT
  } fetch_state_t;

  localparam logic [31:0] V810_RESET_PC = 32'hFFFF_FFF0;

  // Opcodes 6'h28 and above occupy two halfwords.
  function automatic logic insn_is_32(input halfword_t h);
    return h[15] & (h[14] | h[13]);
  endfunction

endpackage

// File: rtl/v810_hwq.sv
// Halfword circular FIFO: pushes 0/1/2 halfwords and pops 0/1/2 halfwords per
// cycle. The head entry and the one after it are visible combinationally.
module v810_hwq
  import v810_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          clr,
  input  logic [1:0]    push_cnt,
  input  halfword_t     push_d0,
  input  halfword_t     push_d1,
  input  logic [1:0]    pop_cnt,
  output halfword_t     head0,
  output halfword_t     head1,
  output logic [CW-1:0] count
);

  halfword_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;

  // Storage writes; the second halfword lands one slot after the first.
  always_ff @(posedge clk) begin
    if (ce && !clr) begin
      if (push_cnt != 2'd0) begin
        mem[wr_ptr_reg] <= push_d0;
      end
      if (push_cnt == 2'd2) begin
        mem[wr_ptr_reg + AW'(1)] <= push_d1;
      end
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (ce) begin
      if (clr) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        rd_ptr_reg <= rd_ptr_reg + AW'(pop_cnt);
        wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
        count_reg  <= count_reg + CW'(push_cnt) - CW'(pop_cnt);
      end
    end
  end

  assign head0 = mem[rd_ptr_reg];
  assign head1 = mem[rd_ptr_reg + AW'(1)];
  assign count = count_reg;

endmodule

// File: rtl/v810_prefetch.sv
// V810 instruction prefetch queue: fetches 32-bit words, buffers halfwords and
// presents one 16/32-bit instruction at a time with its PC. A flush redirects
// fetch; a response still in flight at flush time is dropped.
module v810_prefetch
  import v810_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = V810_RESET_PC,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  output logic [31:0] MA,
  output logic        MRQn,
  input  logic        MACK,
  input  logic [31:0] MD,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  output logic        INST_LEN,
  output logic        INST_VALID,
  input  logic        INST_TAKE
);

  fetch_state_t  state_reg;
  logic [31:0]   ma_reg;
  logic          mrq_n_reg;
  logic [31:0]   fetch_pc_reg;
  logic [31:0]   head_pc_reg;
  logic          skip_reg;
  logic          drop_reg;

  halfword_t     head0;
  halfword_t     head1;
  logic [CW-1:0] count;
  logic          head_is_32;
  logic          inst_valid;

  logic          flush_now;
  logic          ack;
  logic          accept;
  logic          take;
  logic [1:0]    pop_cnt;
  logic [1:0]    push_cnt;
  halfword_t     push_d0;
  halfword_t     push_d1;
  logic [CW-1:0] count_next;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   head_pc_next;
  logic          skip_next;
  logic          drop_next;
  logic          busy_next;
  logic          issue;

  v810_hwq #(
    .DEPTH(DEPTH)
  ) u_hwq (
    .clk     (CLK),
    .rst_n   (RESn),
    .ce      (CE),
    .clr     (flush_now),
    .push_cnt(push_cnt),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop_cnt (pop_cnt),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  assign head_is_32 = insn_is_32(head0);
  assign inst_valid = head_is_32 ? (count >= CW'(2)) : (count >= CW'(1));

  assign INST_VALID = inst_valid;
  assign INST_LEN   = inst_valid & head_is_32;
  assign INST_PC    = inst_valid ? head_pc_reg : 32'h0;
  assign INST       = inst_valid ? {(head_is_32 ? head1 : 16'h0000), head0} : 32'h0;
  assign MA         = ma_reg;
  assign MRQn       = mrq_n_reg;

  // Next-state values for the queue, the PC registers and the fetch decision.
  // A flush outranks both the pop and an arriving word; a word that arrives
  // while drop is set belongs to the abandoned stream and is discarded.
  always_comb begin
    flush_now = CE & FLUSH;
    ack       = CE & (state_reg == FETCH_WAIT) & MACK;
    accept    = ack & ~drop_reg & ~flush_now;
    take      = CE & inst_valid & INST_TAKE & ~FLUSH;

    pop_cnt = 2'd0;
    if (take) begin
      pop_cnt = head_is_32 ? 2'd2 : 2'd1;
    end

    push_cnt = 2'd0;
    if (accept) begin
      push_cnt = skip_reg ? 2'd1 : 2'd2;
    end
    push_d0 = skip_reg ? MD[31:16] : MD[15:0];
    push_d1 = MD[31:16];

    count_next = flush_now ? '0 : (count + CW'(push_cnt) - CW'(pop_cnt));

    fetch_pc_next = fetch_pc_reg;
    if (flush_now) begin
      fetch_pc_next = FLUSH_PC & 32'hFFFF_FFFC;
    end else if (ack && !drop_reg) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    head_pc_next = head_pc_reg;
    if (flush_now) begin
      head_pc_next = FLUSH_PC & 32'hFFFF_FFFE;
    end else if (take) begin
      head_pc_next = head_pc_reg + (head_is_32 ? 32'd4 : 32'd2);
    end

    skip_next = skip_reg;
    if (flush_now) begin
      skip_next = FLUSH_PC[1];
    end else if (accept) begin
      skip_next = 1'b0;
    end

    drop_next = drop_reg;
    if (ack) begin
      drop_next = 1'b0;
    end else if (flush_now && state_reg == FETCH_WAIT) begin
      drop_next = 1'b1;
    end

    // The outstanding word reserves two slots, so a new request is only made
    // once the current one has completed and two slots are free afterwards.
    busy_next = (state_reg == FETCH_WAIT) & ~ack;
    issue     = ~busy_next & ((CW'(DEPTH) - count_next) >= CW'(2));
  end

  // Fetch FSM with registered request outputs, plus PC, skip and drop state.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_reg    <= FETCH_IDLE;
      ma_reg       <= 32'h0;
      mrq_n_reg    <= 1'b1;
      fetch_pc_reg <= RESET_PC;
      head_pc_reg  <= RESET_PC;
      skip_reg     <= 1'b0;
      drop_reg     <= 1'b0;
    end else if (CE) begin
      fetch_pc_reg <= fetch_pc_next;
      head_pc_reg  <= head_pc_next;
      skip_reg     <= skip_next;
      drop_reg     <= drop_next;
      case (state_reg)
        FETCH_IDLE: begin
          if (issue) begin
            state_reg <= FETCH_WAIT;
            mrq_n_reg <= 1'b0;
            ma_reg    <= fetch_pc_next;
          end
        end
        FETCH_WAIT: begin
          if (ack) begin
            if (issue) begin
              ma_reg <= fetch_pc_next;
            end else begin
              state_reg <= FETCH_IDLE;
              mrq_n_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= FETCH_IDLE;
          mrq_n_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v810_prefetch.sv
// Bench for v810_prefetch: a memory responder, an instruction-stream reference
// model feeding an expectation queue, and a monitor that checks every take.
module tb_v810_prefetch;

  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF0;

  logic        CLK = 1'b0;
  logic        RESn = 1'b1;
  logic        CE = 1'b0;
  logic        MACK = 1'b0;
  logic [31:0] MD = 32'h0;
  logic        FLUSH = 1'b0;
  logic [31:0] FLUSH_PC = 32'h0;
  logic        INST_TAKE = 1'b0;
  logic [31:0] MA;
  logic        MRQn;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_LEN;
  logic        INST_VALID;

  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] last_req = 32'h0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          resp_en = 1'b1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        len;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_pc = RPC;
  logic [31:0] mem_ovr [logic [31:0]];

  v810_prefetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(RPC)
  ) dut (
    .CLK       (CLK),
    .RESn      (RESn),
    .CE        (CE),
    .MA        (MA),
    .MRQn      (MRQn),
    .MACK      (MACK),
    .MD        (MD),
    .FLUSH     (FLUSH),
    .FLUSH_PC  (FLUSH_PC),
    .INST      (INST),
    .INST_PC   (INST_PC),
    .INST_LEN  (INST_LEN),
    .INST_VALID(INST_VALID),
    .INST_TAKE (INST_TAKE)
  );

  always #5 CLK = ~CLK;

  // Memory contents: explicit words where placed, a fixed hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ (a >> 7) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Next instruction of the program as seen from model_pc.
  task automatic gen_one();
    logic [15:0] h;
    exp_t        e;
    h    = mem_hw(model_pc);
    e.pc = model_pc;
    if (h[15:10] >= 6'h28) begin
      e.inst   = {mem_hw(model_pc + 32'd2), h};
      e.len    = 1'b1;
      model_pc = model_pc + 32'd4;
    end else begin
      e.inst   = {16'h0000, h};
      e.len    = 1'b0;
      model_pc = model_pc + 32'd2;
    end
    exp_q.push_back(e);
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = {pc[31:1], 1'b0};
    for (int k = 0; k < 16; k++) gen_one();
  endtask

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    FLUSH_PC = pc;
    FLUSH    = 1'b1;
    restart(pc);
    tick();
    FLUSH    = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!INST_VALID && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'b0, INST_VALID}, 32'd1);
  endtask

  task automatic wait_req(input int r, input string name);
    int n = 0;
    while (req_cnt <= r && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'b0, (req_cnt > r)}, 32'd1);
  endtask

  task automatic wait_wait_state(input string name);
    int n = 0;
    while (!(MRQn == 1'b0 && MACK == 1'b0) && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'b0, (MRQn == 1'b0 && MACK == 1'b0)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mrqn"},  {31'b0, MRQn},       32'd1);
    check({tag, "_ma"},    MA,                  32'h0);
    check({tag, "_valid"}, {31'b0, INST_VALID}, 32'd0);
    check({tag, "_inst"},  INST,                32'h0);
    check({tag, "_pc"},    INST_PC,             32'h0);
    check({tag, "_len"},   {31'b0, INST_LEN},   32'd0);
  endtask

  // Monitor: every instruction exec consumes must be the next expected one.
  always @(negedge CLK) begin
    if (RESn && CE && INST_VALID && INST_TAKE && !FLUSH) begin
      $display("TAKE pc=%h inst=%h len=%0d", INST_PC, INST, INST_LEN);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual_pc=%h required=none", INST_PC);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst", INST, mon_e.inst);
        check("inst_pc", INST_PC, mon_e.pc);
        check("inst_len", {31'b0, INST_LEN}, {31'b0, mon_e.len});
        gen_one();
      end
    end
  end

  // Memory responder: one request at a time, MACK held until a CE=1 edge.
  initial begin : responder
    bit          pend;
    bit          fresh;
    bit          ce_e;
    int          lat;
    logic [31:0] req_ma;
    pend   = 1'b0;
    lat    = 0;
    req_ma = 32'h0;
    forever begin
      @(posedge CLK);
      ce_e = CE;
      #2;
      if (!RESn || !resp_en) begin
        if (resp_en) MACK = 1'b0;
        pend = 1'b0;
        continue;
      end
      if (MACK && ce_e) begin
        MACK = 1'b0;
        pend = 1'b0;
        ack_cnt++;
      end
      fresh = 1'b0;
      if (!pend && !MRQn) begin
        pend     = 1'b1;
        fresh    = 1'b1;
        req_ma   = MA;
        last_req = MA;
        req_cnt++;
        lat      = $urandom_range(lat_hi, lat_lo);
        check("ma_align", {30'b0, MA[1:0]}, 32'd0);
      end
      if (pend && !fresh) begin
        check("ma_stable", MA, req_ma);
        check("mrqn_held", {31'b0, MRQn}, 32'd0);
      end
      if (pend && !MACK) begin
        if (lat == 0) begin
          MACK = 1'b1;
          MD   = mem_word(req_ma);
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r;
    int a;
    mem_ovr[RPC] = 32'h0000_A018;
    for (int k = 0; k < 8; k++) mem_ovr[32'h1000 + 32'(4 * k)] = 32'h1C20_1C21 + 32'(k);
    mem_ovr[32'h2000] = 32'hA018_1C20;
    mem_ovr[32'h2004] = 32'h0000_0005;
    mem_ovr[32'h0100] = 32'h0AAA_5555;
    restart(RPC);

    // Reset state
    #1 RESn = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // Release: first fetch at RESET_PC, 32-bit instruction from one word
    r    = req_cnt;
    RESn = 1'b1;
    CE   = 1'b1;
    wait_req(r, "first_req_seen");
    check("first_ma", last_req, RPC);
    wait_valid("first_valid");
    check("first_inst", INST, 32'h0000_A018);
    check("first_len", {31'b0, INST_LEN}, 32'd1);
    check("first_pc", INST_PC, RPC);

    // 16-bit stream with no takes: exactly DEPTH/2 words fetched
    repeat (30) tick();
    a = ack_cnt;
    do_flush(32'h0000_1000);
    repeat (30) tick();
    check("fill_words", 32'(ack_cnt - a), 32'(DEPTH / 2));
    check("fill_mrqn_idle", {31'b0, MRQn}, 32'd1);
    INST_TAKE = 1'b1;
    repeat (40) tick();

    // Instruction spanning a word boundary
    INST_TAKE = 1'b0;
    repeat (20) tick();
    do_flush(32'h0000_2000);
    wait_valid("span_first_valid");
    check("span_first_inst", INST, 32'h0000_1C20);
    check("span_first_pc", INST_PC, 32'h0000_2000);
    check("span_first_len", {31'b0, INST_LEN}, 32'd0);
    INST_TAKE = 1'b1;
    tick();
    INST_TAKE = 1'b0;
    wait_valid("span_second_valid");
    check("span_second_inst", INST, 32'h0005_A018);
    check("span_second_pc", INST_PC, 32'h0000_2002);
    check("span_second_len", {31'b0, INST_LEN}, 32'd1);
    INST_TAKE = 1'b1;
    repeat (20) tick();

    // Flush while a request is outstanding, to a halfword-offset target
    lat_lo = 3;
    lat_hi = 3;
    wait_wait_state("flush_wait_reached");
    r = req_cnt;
    do_flush(32'h0000_0102);
    wait_req(r, "flush_reissue_seen");
    check("flush_reissue_ma", last_req, 32'h0000_0100);
    lat_lo = 0;
    lat_hi = 2;
    repeat (20) tick();

    // Flush and take together: nothing popped, queue empty afterwards
    INST_TAKE = 1'b0;
    repeat (20) tick();
    wait_valid("flush_take_valid");
    INST_TAKE = 1'b1;
    do_flush(32'h0000_3001);
    INST_TAKE = 1'b0;
    check("flush_take_empty", {31'b0, INST_VALID}, 32'd0);
    INST_TAKE = 1'b1;
    repeat (20) tick();

    // Reset pulsed during an outstanding fetch, stale MACK afterwards
    lat_lo = 3;
    lat_hi = 3;
    wait_wait_state("reset_wait_reached");
    @(negedge CLK);
    #2;
    RESn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    restart(RPC);
    tick();
    resp_en = 1'b0;
    MACK    = 1'b1;
    MD      = 32'hDEAD_BEEF;
    tick();
    RESn = 1'b1;
    tick();
    check("restart_mrqn", {31'b0, MRQn}, 32'd0);
    check("restart_ma", MA, RPC);
    r       = req_cnt;
    MACK    = 1'b0;
    resp_en = 1'b1;
    wait_req(r, "restart_req_seen");
    check("restart_req_ma", last_req, RPC);
    lat_lo = 0;
    lat_hi = 3;
    repeat (20) tick();

    // Randomized traffic: clock enable, takes, flushes and latency
    for (int i = 0; i < 2500; i++) begin
      CE        = ($urandom_range(0, 7) != 0);
      INST_TAKE = ($urandom_range(0, 3) != 0);
      if (CE && $urandom_range(0, 99) < 3) begin
        FLUSH_PC = $urandom;
        FLUSH    = 1'b1;
        restart(FLUSH_PC);
      end else begin
        FLUSH = 1'b0;
      end
      tick();
    end
    FLUSH     = 1'b0;
    CE        = 1'b1;
    INST_TAKE = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
